// File: rtl/mem_pkg.sv
// mem_pkg: shared funct3 codes, responder FSM states and RV32I lane/extend helpers.
package mem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] addr);
    lane_mask = funct3[1:0] == 2'b00 ? 4'b0001 << addr :
                funct3[1:0] == 2'b01 ? 4'b0011 << {addr[1], 1'b0} :
                funct3[1:0] == 2'b10 ? 4'b1111 : 4'b0000;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] funct3, input logic [1:0] addr,
                                              input logic [31:0] word);
    logic [31:0] s;
    s = word >> {addr, 3'b000};
    load_extend = funct3 == F3_B  ? {{24{s[7]}}, s[7:0]} :
                  funct3 == F3_BU ? {24'h0, s[7:0]} :
                  funct3 == F3_H  ? {{16{s[15]}}, s[15:0]} :
                  funct3 == F3_HU ? {16'h0, s[15:0]} :
                  funct3 == F3_W  ? word : 32'h0;
  endfunction

  // Misalignment or a funct3 that has no meaning for the access direction.
  function automatic logic access_err(input logic we, input logic [2:0] funct3, input logic [1:0] addr);
    logic mis;
    logic ill;
    mis = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr != 2'b00);
    ill = funct3[1:0] == 2'b11 || (we ? funct3[2] : funct3 == 3'b110);
    access_err = mis || ill;
  endfunction
endpackage

// File: rtl/byte_ram.sv
// byte_ram: four byte-wide banks with per-lane synchronous write and word-indexed async read.
module byte_ram #(
  parameter int IDX_WIDTH = 15
) (
  input  logic                 clk_i,
  input  logic [3:0]           be,
  input  logic [IDX_WIDTH-1:0] idx,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);
  for (genvar b = 0; b < 4; b++) begin : g_bank
    logic [7:0] mem [2**IDX_WIDTH];
    always_ff @(posedge clk_i)
      if (be[b]) mem[idx] <= wdata[8*b +: 8];
    assign rdata[8*b +: 8] = mem[idx];
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: handshaked multi-cycle RV32I load/store responder with stall output.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [31:0]           req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  stall_o
);
  state_e                  state, state_nx;
  logic [3:0]              cnt, cnt_nx;
  logic                    we_q, err_q;
  logic [2:0]              f3_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    idle, cap, go_resp;
  logic                    a_we, a_err;
  logic [2:0]              a_f3;
  logic [ADDR_WIDTH-1:0]   a_addr;
  logic [DATA_WIDTH-1:0]   a_wdata, ram_rdata;
  logic [3:0]              be;
  logic                    unused_addr;

  assign unused_addr = ^req_addr_i[31:ADDR_WIDTH];
  assign idle    = state == IDLE;
  assign cap     = idle && req_valid_i;
  // With LATENCY 1 or an error the access lands on the accept edge, so bypass the capture regs.
  assign a_we    = idle ? req_we_i : we_q;
  assign a_f3    = idle ? req_funct3_i : f3_q;
  assign a_addr  = idle ? req_addr_i[ADDR_WIDTH-1:0] : addr_q;
  assign a_wdata = idle ? req_wdata_i : wdata_q;
  assign a_err   = idle ? access_err(req_we_i, req_funct3_i, req_addr_i[1:0]) : err_q;
  assign go_resp = state != RESP && state_nx == RESP;
  assign be      = go_resp && a_we && !a_err ? lane_mask(a_f3, a_addr[1:0]) : 4'b0000;

  assign req_ready_o = idle;
  assign rsp_valid_o = state == RESP;
  assign stall_o     = cap || state == WAIT || (state == RESP && !rsp_ready_i);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (req_valid_i) begin
        state_nx = (LATENCY == 1 || a_err) ? RESP : WAIT;
        cnt_nx   = 4'(LATENCY - 1);
      end
      WAIT: begin
        cnt_nx   = cnt - 4'd1;
        state_nx = cnt == 4'd1 ? RESP : WAIT;
      end
      RESP: state_nx = rsp_ready_i ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      f3_q        <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (cap) begin
        we_q    <= req_we_i;
        err_q   <= a_err;
        f3_q    <= req_funct3_i;
        addr_q  <= req_addr_i[ADDR_WIDTH-1:0];
        wdata_q <= req_wdata_i;
      end
      if (go_resp) begin
        rsp_rdata_o <= (a_we || a_err) ? '0 : load_extend(a_f3, a_addr[1:0], ram_rdata);
        rsp_err_o   <= a_err;
      end
    end

  byte_ram #(.IDX_WIDTH(ADDR_WIDTH - 2)) u_ram (
    .clk_i (clk_i),
    .be    (be),
    .idx   (a_addr[ADDR_WIDTH-1:2]),
    .wdata (a_wdata << {a_addr[1:0], 3'b000}),
    .rdata (ram_rdata)
  );
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Memory-side responder for the pipeline's M-stage load/store port, replacing the single-cycle data_memory with a handshaked, multi-cycle, byte-addressable RAM. It accepts one request at a time and performs RV32I sub-word access: byte/half/word writes with lane masking, and sign/zero-extended loads. It also flags misaligned or illegal accesses. It drives a stall back to the hazard unit while an access is outstanding.

Parameters:
ADDR_WIDTH, 17, byte-address bits decoded; memory is 2**ADDR_WIDTH bytes
DATA_WIDTH, 32, data bus width; fixed at 32
LATENCY, 2, cycles from request accept to rsp_valid_o; legal range 1..15

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  M-stage presents a request
req_ready_o  out  1  responder can accept a request
req_we_i  in  1  1 = store, 0 = load
req_funct3_i  in  3  RV32I funct3 access size/sign
req_addr_i  in  32  byte address (ALUResultM)
req_wdata_i  in  32  store data (WriteDataM), right-aligned
rsp_valid_o  out  1  response available
rsp_ready_i  in  1  consumer accepts response
rsp_rdata_o  out  32  extended load data; 0 for stores and errors
rsp_err_o  out  1  misaligned or illegal funct3; qualified by rsp_valid_o
stall_o  out  1  to hazard unit: hold F/D/E/M

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_ni.
- Reset values: state=IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, latency counter=0. RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, capture we/funct3/addr/wdata.
  - Go to RESP if LATENCY==1 or the request is erroneous; otherwise load counter with LATENCY-1 and go to WAIT.
- WAIT:
  - req_ready_o=0; counter decrements each cycle.
  - At counter==1, go to RESP.
- RESP entry edge (the single point where the access takes effect):
  - Store: RAM written.
  - Load: rsp_rdata_o registered.
- RESP:
  - rsp_valid_o=1; outputs held stable until rsp_ready_i.
  - On rsp_valid_o && rsp_ready_i, return to IDLE.
  - No new request is accepted in the same cycle; the next accept is one cycle later.
- Latency: a request accepted at edge t gives rsp_valid_o high after edge t+LATENCY. An error response is always ready after edge t+1.
- stall_o = (IDLE && req_valid_i) || WAIT || (RESP && !rsp_ready_i). This is combinational; it drops in the cycle the response handshake completes.
- Address decode:
  - Only req_addr_i[ADDR_WIDTH-1:0] is used; upper bits are ignored, so addresses wrap modulo 2**ADDR_WIDTH.
  - Byte order is little-endian.
- Loads:
  - 000 LB and 100 LBU: byte, sign- or zero-extended.
  - 001 LH and 101 LHU: halfword, sign- or zero-extended.
  - 010 LW: word.
- Stores:
  - 000 SB writes 1 lane, from wdata[7:0].
  - 001 SH writes 2 lanes, from wdata[15:0].
  - 010 SW writes 4 lanes.
  - Unaddressed bytes are unchanged.
- Errors (rsp_err_o=1, no RAM write, rsp_rdata_o=0):
  - Half access with addr[0]!=0.
  - Word access with addr[1:0]!=0.
  - Load funct3 of 011/110/111.
  - Store funct3 other than 000/001/010.
- Ordering: a load issued after a store has completed returns the stored data; there is no write buffering.
- Reset mid-operation: an access still in WAIT is dropped and its store is not performed. After reset deasserts, the FSM is in IDLE.
- req_* inputs are ignored outside IDLE.

Decomposition:
- Shared package mem_pkg:
  - funct3 localparams F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - State enum state_e {IDLE, WAIT, RESP}.
  - Function lane_mask(funct3, addr[1:0]) returning 4 bits.
  - Function load_extend(funct3, addr[1:0], word) returning 32 bits.
- Sub-module byte_ram: 4 byte-wide banks, synchronous write with 4-bit lane enable, word-indexed read.

Test Plan:
- SW addr 0x100 data 0xDEADBEEF, then LW 0x100 -> rsp_rdata_o=0xDEADBEEF, rsp_err_o=0; rsp_valid_o rises exactly LATENCY=2 cycles after accept; stall_o high for 2 cycles.
- After the above, SB addr 0x101 data 0x000000AA, then LW 0x100 -> 0xDEADAAEF. LB 0x101 -> 0xFFFFFFAA. LBU 0x101 -> 0x000000AA.
- SH addr 0x102 data 0x00008001, then LH 0x102 -> 0xFFFF8001; LHU 0x102 -> 0x00008001.
- LW addr 0x102 -> rsp_err_o=1, rsp_rdata_o=0 one cycle after accept. SH 0x103 -> err, and LW 0x100 afterward is unchanged. Load funct3=011 -> err.
- Hold rsp_ready_i=0 for 3 cycles in RESP -> rsp_valid_o, rsp_rdata_o and stall_o held. Raise rsp_ready_i -> stall_o drops the same cycle; IDLE next cycle.
- SW 0x200 data 0x12345678; assert rst_ni=0 during WAIT -> all outputs at reset values. Then LW 0x200 returns the prior contents (0x12345678 not written). Also: address 0x00020100 with ADDR_WIDTH=17 aliases to 0x100.
